// File: rtl/wb_stage.sv
// wb_stage: pipeline write-back stage.
// Commits ALU results one cycle after acceptance. Loads wait in WAIT for
// memory data, bounded by MAX_WAIT cycles; a timeout sets a sticky load_err.
// Optional feature macro: WB_FORWARD_EN adds the fwd_* bypass outputs for
// the decode stage.
module wb_stage #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_reg_write,
  input  logic [4:0]  in_rd,
  input  logic        in_is_load,
  input  logic [31:0] in_alu_result,
  input  logic        mem_rdata_valid,
  input  logic [31:0] mem_rdata,
  input  logic        flush,
  output logic        reg_write,
  output logic [4:0]  num_write,
  output logic [31:0] data_write,
  output logic        busy,
  output logic        load_err
`ifdef WB_FORWARD_EN
  ,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data
`endif
);

  localparam int unsigned RW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [RW-1:0] rd_q;
  logic          wen_q;
  logic          reg_write_q;
  logic [RW-1:0] num_write_q;
  logic [DW-1:0] data_write_q;
  logic          load_err_q;
  logic          transfer;

  // Handshake: accept only in IDLE, and never while a flush is asserted.
  assign in_ready = (state_q == S_IDLE) & ~flush;
  assign transfer = in_valid & in_ready;

  // FSM, wait counter and registered register-file write port.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rd_q         <= '0;
      wen_q        <= 1'b0;
      reg_write_q  <= 1'b0;
      num_write_q  <= '0;
      data_write_q <= '0;
      load_err_q   <= 1'b0;
    end else begin
      reg_write_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (transfer) begin
            if (in_is_load) begin
              rd_q    <= in_rd;
              wen_q   <= in_reg_write;
              cnt_q   <= '0;
              state_q <= S_WAIT;
            end else if (in_reg_write && (in_rd != '0)) begin
              // Address/data only move on a real commit so they hold otherwise.
              reg_write_q  <= 1'b1;
              num_write_q  <= in_rd;
              data_write_q <= in_alu_result;
            end
          end
        end
        S_WAIT: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else if (mem_rdata_valid) begin
            if (wen_q && (rd_q != '0)) begin
              reg_write_q  <= 1'b1;
              num_write_q  <= rd_q;
              data_write_q <= mem_rdata;
            end
            state_q <= S_IDLE;
          end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
            load_err_q <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign reg_write  = reg_write_q;
  assign num_write  = num_write_q;
  assign data_write = data_write_q;
  assign busy       = (state_q == S_WAIT);
  assign load_err   = load_err_q;

`ifdef WB_FORWARD_EN
  // Bypass view of the write port for the decode stage.
  assign fwd_valid = reg_write_q;
  assign fwd_rd    = num_write_q;
  assign fwd_data  = data_write_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage (default build, MAX_WAIT=15).
module tb_wb_stage;

  logic        clock;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic        in_is_load;
  logic [31:0] in_alu_result;
  logic        mem_rdata_valid;
  logic [31:0] mem_rdata;
  logic        flush;
  logic        reg_write;
  logic [4:0]  num_write;
  logic [31:0] data_write;
  logic        busy;
  logic        load_err;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  wb_stage #(.MAX_WAIT(15)) dut (
    .clock           (clock),
    .resetn          (resetn),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_reg_write    (in_reg_write),
    .in_rd           (in_rd),
    .in_is_load      (in_is_load),
    .in_alu_result   (in_alu_result),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata       (mem_rdata),
    .flush           (flush),
    .reg_write       (reg_write),
    .num_write       (num_write),
    .data_write      (data_write),
    .busy            (busy),
    .load_err        (load_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_reg_write = 1'b0; in_rd = '0; in_is_load = 1'b0;
    in_alu_result = '0; mem_rdata_valid = 1'b0; mem_rdata = '0; flush = 1'b0;
  endtask

  task automatic drive(input logic ld, input logic wen, input logic [4:0] rd,
                       input logic [31:0] val);
    in_valid = 1'b1; in_is_load = ld; in_reg_write = wen; in_rd = rd; in_alu_result = val;
  endtask

  // Every committed write must match the oldest expected entry.
  always @(negedge clock) begin
    if (reg_write) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(num_write), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_rd", 32'(num_write), 32'(e.rd));
        chk("sb_data", data_write, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    idle_in();
    resetn = 1'b0;
    #1;
    chk("rst_reg_write", 32'(reg_write), 32'd0);
    chk("rst_num_write", 32'(num_write), 32'd0);
    chk("rst_data_write", data_write, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick(); tick();
    resetn = 1'b1;
    tick();

    // ALU write rd=5, one-cycle pulse, then hold
    drive(1'b0, 1'b1, 5'd5, 32'h0000_00AA);
    chk("alu_ready", 32'(in_ready), 32'd1);
    exp_q.push_back('{5'd5, 32'h0000_00AA});
    tick(); idle_in();
    chk("alu_we", 32'(reg_write), 32'd1);
    chk("alu_rd", 32'(num_write), 32'd5);
    chk("alu_data", data_write, 32'h0000_00AA);
    tick();
    chk("alu_we_drop", 32'(reg_write), 32'd0);
    chk("alu_hold_rd", 32'(num_write), 32'd5);
    chk("alu_hold_data", data_write, 32'h0000_00AA);

    // rd=0 never written
    drive(1'b0, 1'b1, 5'd0, 32'h0000_1234);
    tick(); idle_in();
    chk("rd0_we", 32'(reg_write), 32'd0);

    // back-to-back ALU writes
    for (int i = 0; i < 4; i++) begin
      logic [31:0] v;
      v = $urandom;
      drive(1'b0, 1'b1, 5'(i + 1), v);
      exp_q.push_back('{5'(i + 1), v});
      tick();
    end
    idle_in();
    tick();

    // load rd=9, data three cycles later
    drive(1'b1, 1'b1, 5'd9, 32'h1111_1111);
    exp_q.push_back('{5'd9, 32'hDEAD_BEEF});
    tick(); idle_in();
    for (int i = 0; i < 2; i++) begin
      chk("ld_busy", 32'(busy), 32'd1);
      chk("ld_not_ready", 32'(in_ready), 32'd0);
      tick();
    end
    mem_rdata_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick(); idle_in();
    chk("ld_we", 32'(reg_write), 32'd1);
    chk("ld_rd", 32'(num_write), 32'd9);
    chk("ld_data", data_write, 32'hDEAD_BEEF);
    chk("ld_idle", 32'(busy), 32'd0);
    tick();

    // load timeout after 15 WAIT cycles
    chk("pre_to_err", 32'(load_err), 32'd0);
    drive(1'b1, 1'b1, 5'd3, 32'h0);
    tick(); idle_in();
    n = 0;
    while (busy && n < 40) begin
      if (n == 13) chk("to_err_early", 32'(load_err), 32'd0);
      n++;
      tick();
    end
    chk("to_wait_cycles", 32'(n), 32'd15);
    chk("to_err", 32'(load_err), 32'd1);
    chk("to_ready", 32'(in_ready), 32'd1);
    chk("to_no_we", 32'(reg_write), 32'd0);

    // flush beats data in WAIT
    drive(1'b1, 1'b1, 5'd7, 32'h0);
    tick(); idle_in();
    tick();
    flush = 1'b1; mem_rdata_valid = 1'b1; mem_rdata = 32'h5555_5555;
    chk("fl_not_ready", 32'(in_ready), 32'd0);
    tick(); idle_in();
    chk("fl_no_we", 32'(reg_write), 32'd0);
    chk("fl_idle", 32'(busy), 32'd0);
    chk("fl_err_sticky", 32'(load_err), 32'd1);

    // flush in IDLE blocks a transfer
    drive(1'b0, 1'b1, 5'd4, 32'h0000_4444);
    flush = 1'b1;
    chk("idle_fl_ready", 32'(in_ready), 32'd0);
    tick(); idle_in();
    chk("idle_fl_no_we", 32'(reg_write), 32'd0);

    // stray load data in IDLE ignored
    mem_rdata_valid = 1'b1; mem_rdata = 32'h7777_7777;
    tick(); idle_in();
    chk("idle_md_no_we", 32'(reg_write), 32'd0);
    chk("idle_md_busy", 32'(busy), 32'd0);

    // still operating after load_err
    drive(1'b0, 1'b1, 5'd12, 32'h0000_CAFE);
    exp_q.push_back('{5'd12, 32'h0000_CAFE});
    tick(); idle_in();
    chk("post_err_we", 32'(reg_write), 32'd1);
    tick();

    // load without register write: no commit
    drive(1'b1, 1'b0, 5'd8, 32'h0);
    tick(); idle_in();
    mem_rdata_valid = 1'b1; mem_rdata = 32'h8888_8888;
    tick(); idle_in();
    chk("ld_nowen_we", 32'(reg_write), 32'd0);

    // data on the last allowed WAIT cycle still commits
    drive(1'b1, 1'b1, 5'd20, 32'h0);
    exp_q.push_back('{5'd20, 32'h0BAD_F00D});
    tick(); idle_in();
    for (int i = 0; i < 14; i++) tick();
    chk("last_busy", 32'(busy), 32'd1);
    mem_rdata_valid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    tick(); idle_in();
    chk("last_we", 32'(reg_write), 32'd1);
    tick();

    // reset during WAIT discards the load
    drive(1'b1, 1'b1, 5'd10, 32'h0);
    tick(); idle_in();
    tick();
    resetn = 1'b0;
    #1;
    chk("wrst_busy", 32'(busy), 32'd0);
    chk("wrst_err", 32'(load_err), 32'd0);
    chk("wrst_num", 32'(num_write), 32'd0);
    chk("wrst_data", data_write, 32'd0);
    tick();
    resetn = 1'b1;
    mem_rdata_valid = 1'b1; mem_rdata = 32'h1357_9BDF;
    tick(); idle_in();
    chk("wrst_no_we", 32'(reg_write), 32'd0);
    chk("wrst_err_after", 32'(load_err), 32'd0);
    tick(); tick();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
